lcd_ascii_stream: RTL and testbench
===================================

# lcd_ascii_stream

Sequential, parametrised formatter that turns one decoded instruction (opcode, destination register, signed immediate/value) into the ASCII text shown on the LCD, e.g. "ADD R1, +12", and streams it out one character per handshake beat. It sits between the CPU's display/trace path and the LCD character-write controller. It replaces the single-shot formatting task with a clocked block that does multi-cycle binary-to-decimal conversion, has configurable value and register widths, and includes backpressure and abort.

## Interface
- DATA_W, 16: value width in bits, 4..32.
- REG_W, 4: register-index width, 1..5. Register numbers are printed in decimal.
- SIGNED, 1: 1 = value is two's complement and a sign char is always printed. 0 = value is unsigned and no sign char is printed.
- Derived localparam DIGITS = ceil(DATA_W·log10 2), 5 for DATA_W=16. Maximum message length = 7 (mnemonic) + 2 + 2 (reg) + 2 + SIGNED + DIGITS.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request to format; accepted only when in_ready=1.
- in_ready  out  1  high in IDLE only.
- op  in  4  opcode, sampled at acceptance.
- reg_dest  in  REG_W  destination register, sampled at acceptance.
- valor  in  DATA_W  value, sampled at acceptance.
- abort  in  1  synchronous cancel; returns the block to IDLE next cycle.
- char_valid  out  1  char_data is valid.
- char_ready  in  1  sink accepts the character.
- char_data  out  8  ASCII character.
- char_last  out  1  marks the final character of the message.
- msg_len  out  6  total character count, valid from first char_valid until IDLE.

## Operation
- Mnemonics by op: 0000 LOAD, 0001 ADD, 0010 ADDI, 0011 SUB, 0100 SUBI, 0101 MUL, 0110 CLEAR, 0111 DISPLAY, 1000–1111 "???".
- Message layout: mnemonic, ' ', 'R', register decimal (1 or 2 digits, no leading zero), ',', ' ', sign ('+' or '-', present only when SIGNED=1), magnitude digits. No trailing space or NUL.
- Magnitude: for SIGNED=1, abs(valor) computed in DATA_W+1 bits, so the most-negative value prints correctly (e.g. -32768). Leading zeros are suppressed. Zero prints as "+0" (SIGNED=1) or "0" (SIGNED=0).
- State machine:
  - IDLE: start=1 latches the inputs and moves to CONV.
  - CONV: double-dabble, one input bit per cycle, for exactly DATA_W cycles. Then it computes the digit count and msg_len and moves to EMIT.
  - EMIT: holds char_valid=1 and advances the char index on each char_valid && char_ready. The beat carrying char_last moves to IDLE.
- abort=1 in any state: next state is IDLE, char_valid drops and the message is discarded. abort has priority over start and over a handshake in the same cycle.
- start while not in_ready is ignored, with no queueing.

## Timing
- Reset values: in_ready=1, char_valid=0, char_last=0, char_data=8'h00, msg_len=0, state IDLE. Reset is asynchronous: outputs take these values immediately, including mid-CONV or mid-EMIT, and no partial message resumes.
- Start accepted at edge 0. in_ready=0 from edge 0. CONV occupies edges 1..DATA_W. char_valid=1 with the first character after edge DATA_W+1.
- char_data and char_last are stable while char_valid=1 && char_ready=0. There is no combinational path from char_ready to char_valid.
- Throughput: one character per cycle under continuous char_ready.
- in_ready returns to 1 the cycle after the last-character handshake. A new start may be accepted in that cycle.
- Total latency with char_ready held at 1: DATA_W + 1 + msg_len cycles from acceptance to IDLE.

## Test plan
- ADD, R1, +12 (op=0001, reg=1, valor=16'd12), char_ready=1:
  - stream is "ADD R1, +12";
  - msg_len=11;
  - char_last on '2';
  - first char_valid at DATA_W+1 after acceptance.
- SUBI, R2, -13 (op=0100, reg=2, valor=16'hFFF3), with char_ready toggling 1,0,0,1…:
  - stream is "SUBI R2, -13", msg_len=12;
  - char_data is held through every stall.
- DISPLAY, R9, +7 (op=0111, reg=9, valor=7) -> "DISPLAY R9, +7", msg_len=14.
- Boundaries:
  - reg=15, valor=16'h8000 -> "… R15, -32768";
  - valor=0 -> "+0";
  - op=1111 -> "???";
  - SIGNED=0, DATA_W=8, valor=8'hFF -> "… 255" with no sign char.
- Abort and start handling:
  - abort during CONV -> no char_valid, and in_ready=1 the next cycle;
  - abort on the same cycle as a char handshake -> IDLE, no further characters;
  - start asserted while busy -> ignored.
- rst_n pulsed low mid-EMIT:
  - outputs reach reset values asynchronously;
  - after release, a new request produces a complete, correct message.

Source files
------------

// File: rtl/lcd_ascii_stream_if.sv
// Handshake bundle for lcd_ascii_stream.
// Request side:   start/in_ready, op, reg_dest, valor, abort.
// Character side: char_valid/char_ready, char_data, char_last, msg_len.
// master = the instruction source plus the LCD sink (the bench); slave = the formatter.
interface lcd_ascii_stream_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_W  = 4
);
  logic              start;
  logic              in_ready;
  logic [3:0]        op;
  logic [REG_W-1:0]  reg_dest;
  logic [DATA_W-1:0] valor;
  logic              abort;
  logic              char_valid;
  logic              char_ready;
  logic [7:0]        char_data;
  logic              char_last;
  logic [5:0]        msg_len;

  modport master (
    output start, op, reg_dest, valor, abort, char_ready,
    input  in_ready, char_valid, char_data, char_last, msg_len
  );

  modport slave (
    input  start, op, reg_dest, valor, abort, char_ready,
    output in_ready, char_valid, char_data, char_last, msg_len
  );
endinterface

// File: rtl/lcd_ascii_stream.sv
// Formats one decoded instruction as LCD text, e.g. "ADD R1, +12", and streams it out one
// character per valid/ready beat.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - slave side of lcd_ascii_stream_if (request, abort, character stream, msg_len)
// Flow: IDLE latches the request, CONV runs a bit-serial double-dabble for DATA_W cycles and
// then sizes the message, EMIT walks a character index across the message fields.
module lcd_ascii_stream #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_W  = 4,
  parameter bit          SIGNED = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  lcd_ascii_stream_if.slave bus
);
  // Decimal digits needed for 2**w - 1, i.e. ceil(w * log10(2)).
  function automatic int unsigned calc_digits(input int unsigned w);
    longint unsigned v;
    int unsigned     n;
    v = (64'd1 << w) - 64'd1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (v != 64'd0) begin
        v = v / 64'd10;
        n++;
      end
    end
    return n;
  endfunction

  localparam int unsigned DIGITS  = calc_digits(DATA_W);
  localparam int unsigned BCD_W   = 4 * DIGITS;
  localparam int unsigned CNT_W   = $clog2(DATA_W + 1);
  localparam logic [5:0]  SGN_LEN = SIGNED ? 6'd1 : 6'd0;

  typedef enum logic [1:0] {StIdle, StConv, StEmit} state_e;

  state_e            r_state,   w_state_nxt;
  logic [CNT_W-1:0]  r_cnt,     w_cnt_nxt;
  logic [DATA_W-1:0] r_bin,     w_bin_nxt;
  logic [BCD_W-1:0]  r_bcd,     w_bcd_nxt;
  logic [3:0]        r_op,      w_op_nxt;
  logic [REG_W-1:0]  r_reg,     w_reg_nxt;
  logic              r_neg,     w_neg_nxt;
  logic [3:0]        r_ndig,    w_ndig_nxt;
  logic [5:0]        r_msg_len, w_msg_len_nxt;
  logic [5:0]        r_idx,     w_idx_nxt;

  logic [DATA_W:0]   w_val_ext, w_mag;
  logic [BCD_W-1:0]  w_bcd_adj, w_bcd_shift, w_bcd_sh;
  logic [3:0]        w_ndig_calc;
  logic [55:0]       w_mnem_txt, w_mnem_sh;
  logic [5:0]        w_mnem_len, w_reg6, w_reg_tens, w_reg_ones, w_rdig;
  logic [5:0]        w_p_reg, w_p_comma, w_p_dig, w_len_calc, w_dig_pos;
  logic [7:0]        w_char;
  logic              w_emit, w_last;

  // Magnitude in DATA_W+1 bits so the most-negative value negates cleanly.
  always_comb begin
    w_val_ext = {SIGNED & bus.valor[DATA_W-1], bus.valor};
    w_mag     = w_val_ext[DATA_W] ? (~w_val_ext + {{DATA_W{1'b0}}, 1'b1}) : w_val_ext;
  end

  // Double-dabble step: add 3 to every digit >= 5, then shift the next binary bit in.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
    w_bcd_shift = {w_bcd_adj[BCD_W-2:0], r_bin[DATA_W-1]};
    // Leading-zero suppression; zero still prints one digit.
    w_ndig_calc = 4'd1;
    for (int i = 1; i < int'(DIGITS); i++) begin
      if (r_bcd[4*i +: 4] != 4'd0) w_ndig_calc = 4'(i + 1);
    end
  end

  // Field layout of the latched instruction; text is left-aligned in w_mnem_txt.
  always_comb begin
    unique case (r_op)
      4'd0:    begin w_mnem_txt = {"LOAD", 24'h0};  w_mnem_len = 6'd4; end
      4'd1:    begin w_mnem_txt = {"ADD", 32'h0};   w_mnem_len = 6'd3; end
      4'd2:    begin w_mnem_txt = {"ADDI", 24'h0};  w_mnem_len = 6'd4; end
      4'd3:    begin w_mnem_txt = {"SUB", 32'h0};   w_mnem_len = 6'd3; end
      4'd4:    begin w_mnem_txt = {"SUBI", 24'h0};  w_mnem_len = 6'd4; end
      4'd5:    begin w_mnem_txt = {"MUL", 32'h0};   w_mnem_len = 6'd3; end
      4'd6:    begin w_mnem_txt = {"CLEAR", 16'h0}; w_mnem_len = 6'd5; end
      4'd7:    begin w_mnem_txt = "DISPLAY";        w_mnem_len = 6'd7; end
      default: begin w_mnem_txt = {"???", 32'h0};   w_mnem_len = 6'd3; end
    endcase
    w_reg6     = 6'(r_reg);
    w_reg_tens = w_reg6 / 6'd10;
    w_reg_ones = w_reg6 % 6'd10;
    w_rdig     = (w_reg6 >= 6'd10) ? 6'd2 : 6'd1;
    w_p_reg    = w_mnem_len + 6'd2;
    w_p_comma  = w_p_reg + w_rdig;
    w_p_dig    = w_p_comma + 6'd2 + SGN_LEN;
    w_len_calc = w_p_dig + {2'b00, w_ndig_calc};
  end

  // Character at r_idx; depends only on registers, so it holds steady through stalls.
  always_comb begin
    w_mnem_sh = w_mnem_txt >> {6'd6 - r_idx, 3'b000};
    w_dig_pos = {2'b00, r_ndig} - 6'd1 - (r_idx - w_p_dig);
    w_bcd_sh  = r_bcd >> {w_dig_pos, 2'b00};
    w_char    = 8'h20;
    if (r_idx < w_mnem_len)                  w_char = w_mnem_sh[7:0];
    else if (r_idx == w_mnem_len)            w_char = 8'h20;
    else if (r_idx == w_mnem_len + 6'd1)     w_char = "R";
    else if (r_idx == w_p_reg)               w_char = 8'h30 + {2'b00,
                                                (w_rdig == 6'd2) ? w_reg_tens : w_reg_ones};
    else if (r_idx < w_p_comma)              w_char = 8'h30 + {2'b00, w_reg_ones};
    else if (r_idx == w_p_comma)             w_char = ",";
    else if (r_idx == w_p_comma + 6'd1)      w_char = 8'h20;
    else if (r_idx < w_p_dig)                w_char = r_neg ? "-" : "+";
    else                                     w_char = 8'h30 + {4'h0, w_bcd_sh[3:0]};
  end

  assign w_emit = (r_state == StEmit);
  assign w_last = w_emit && (r_idx == r_msg_len - 6'd1);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bin_nxt     = r_bin;
    w_bcd_nxt     = r_bcd;
    w_op_nxt      = r_op;
    w_reg_nxt     = r_reg;
    w_neg_nxt     = r_neg;
    w_ndig_nxt    = r_ndig;
    w_msg_len_nxt = r_msg_len;
    w_idx_nxt     = r_idx;
    unique case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_op_nxt    = bus.op;
          w_reg_nxt   = bus.reg_dest;
          w_neg_nxt   = w_val_ext[DATA_W];
          w_bin_nxt   = w_mag[DATA_W-1:0];
          w_bcd_nxt   = '0;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_state_nxt = StConv;
        end
      end
      StConv: begin
        // One extra cycle after the last shift to size the message from the finished BCD.
        if (r_cnt == CNT_W'(DATA_W)) begin
          w_ndig_nxt    = w_ndig_calc;
          w_msg_len_nxt = w_len_calc;
          w_state_nxt   = StEmit;
        end else begin
          w_bcd_nxt = w_bcd_shift;
          w_bin_nxt = {r_bin[DATA_W-2:0], 1'b0};
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      StEmit: begin
        if (bus.char_ready) begin
          if (w_last) w_state_nxt = StIdle;
          else        w_idx_nxt   = r_idx + 6'd1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
    if (bus.abort) w_state_nxt = StIdle;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_bin     <= '0;
      r_bcd     <= '0;
      r_op      <= '0;
      r_reg     <= '0;
      r_neg     <= 1'b0;
      r_ndig    <= '0;
      r_msg_len <= '0;
      r_idx     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bin     <= w_bin_nxt;
      r_bcd     <= w_bcd_nxt;
      r_op      <= w_op_nxt;
      r_reg     <= w_reg_nxt;
      r_neg     <= w_neg_nxt;
      r_ndig    <= w_ndig_nxt;
      r_msg_len <= w_msg_len_nxt;
      r_idx     <= w_idx_nxt;
    end
  end

  assign bus.in_ready   = (r_state == StIdle);
  assign bus.char_valid = w_emit;
  assign bus.char_data  = w_emit ? w_char : 8'h00;
  assign bus.char_last  = w_last;
  assign bus.msg_len    = r_msg_len;
endmodule

// File: tb/tb_lcd_ascii_stream.sv
// Bench for lcd_ascii_stream: a signed 16-bit instance and an unsigned 8-bit instance.
// Expected characters are pushed to per-instance queues when a request is driven and popped
// by negedge monitors on every accepted character beat.
module tb_lcd_ascii_stream;
  typedef struct {
    logic [7:0] ch;
    logic       last;
    int         len;
  } exp_t;

  logic clk;
  logic rst_n;

  lcd_ascii_stream_if #(.DATA_W(16), .REG_W(4)) m_if ();
  lcd_ascii_stream_if #(.DATA_W(8),  .REG_W(4)) u_if ();

  lcd_ascii_stream #(.DATA_W(16), .REG_W(4), .SIGNED(1'b1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m_if.slave)
  );

  lcd_ascii_stream #(.DATA_W(8), .REG_W(4), .SIGNED(1'b0)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  exp_t       q_m[$];
  exp_t       q_u[$];
  int         rdy_mode = 0;
  int         rdy_ph   = 0;
  logic       stall_seen = 1'b0;
  logic [7:0] stall_char = 8'h00;
  logic       watch_quiet = 1'b0;
  int         valid_seen = 0;

  logic [3:0]  t_op  [7] = '{4'd7, 4'd0, 4'd15, 4'd5, 4'd6, 4'd2, 4'd3};
  logic [3:0]  t_reg [7] = '{4'd9, 4'd15, 4'd3, 4'd10, 4'd12, 4'd0, 4'd7};
  logic [15:0] t_val [7] = '{16'd7, 16'h8000, 16'd0, 16'h7FFF, 16'hFFFF, 16'd100, 16'd9};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  function automatic string fmt_msg(input int op, input int rg, input longint v, input bit sgn);
    string mn;
    string sg;
    case (op)
      0:       mn = "LOAD";
      1:       mn = "ADD";
      2:       mn = "ADDI";
      3:       mn = "SUB";
      4:       mn = "SUBI";
      5:       mn = "MUL";
      6:       mn = "CLEAR";
      7:       mn = "DISPLAY";
      default: mn = "???";
    endcase
    sg = !sgn ? "" : ((v < 0) ? "-" : "+");
    return $sformatf("%s R%0d, %s%0d", mn, rg, sg, (v < 0) ? -v : v);
  endfunction

  function automatic void push_msg(input string s, input bit to_u);
    exp_t e;
    for (int i = 0; i < s.len(); i++) begin
      e.ch   = s[i];
      e.last = (i == s.len() - 1);
      e.len  = s.len();
      if (to_u) q_u.push_back(e);
      else      q_m.push_back(e);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input logic [3:0] op, input logic [3:0] rg, input logic [15:0] val,
                         input bit push);
    int k = 0;
    while (m_if.in_ready !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    check("m_ready_wait", m_if.in_ready, 1);
    if (push) push_msg(fmt_msg(op, rg, longint'($signed(val)), 1'b1), 1'b0);
    m_if.op       = op;
    m_if.reg_dest = rg;
    m_if.valor    = val;
    m_if.start    = 1'b1;
    tick();
    m_if.start    = 1'b0;
  endtask

  task automatic wait_m(input string tag);
    int k = 0;
    while (!(m_if.in_ready === 1'b1 && q_m.size() == 0) && k < 400) begin
      tick();
      k++;
    end
    check(tag, 32'(q_m.size()), 0);
    check({tag, "_idle"}, m_if.in_ready, 1);
  endtask

  task automatic drive_u(input logic [3:0] op, input logic [3:0] rg, input logic [7:0] val);
    int k = 0;
    push_msg(fmt_msg(op, rg, longint'(val), 1'b0), 1'b1);
    u_if.op       = op;
    u_if.reg_dest = rg;
    u_if.valor    = val;
    u_if.start    = 1'b1;
    tick();
    u_if.start    = 1'b0;
    while (!(u_if.in_ready === 1'b1 && q_u.size() == 0) && k < 200) begin
      tick();
      k++;
    end
    check("u_done", 32'(q_u.size()), 0);
  endtask

  task automatic quiet_window(input string tag, input int cycles);
    valid_seen  = 0;
    watch_quiet = 1'b1;
    repeat (cycles) tick();
    watch_quiet = 1'b0;
    check(tag, 32'(valid_seen), 0);
  endtask

  task automatic mon_m();
    exp_t e;
    if (rst_n !== 1'b1) return;
    if (stall_seen) begin
      check("stall_valid", m_if.char_valid, 1);
      check("stall_hold", m_if.char_data, stall_char);
    end
    stall_seen = m_if.char_valid && !m_if.char_ready;
    stall_char = m_if.char_data;
    if (watch_quiet && m_if.char_valid) valid_seen++;
    if (m_if.char_valid && m_if.char_ready && !m_if.abort) begin
      if (q_m.size() == 0) begin
        check("m_extra_char", m_if.char_valid, 0);
      end else begin
        e = q_m.pop_front();
        check("m_char", m_if.char_data, e.ch);
        check("m_last", m_if.char_last, e.last);
        check("m_len", 32'(m_if.msg_len), e.len);
      end
    end
  endtask

  task automatic mon_u();
    exp_t e;
    if (rst_n !== 1'b1) return;
    if (u_if.char_valid && u_if.char_ready) begin
      if (q_u.size() == 0) begin
        check("u_extra_char", u_if.char_valid, 0);
      end else begin
        e = q_u.pop_front();
        check("u_char", u_if.char_data, e.ch);
        check("u_last", u_if.char_last, e.last);
        check("u_len", 32'(u_if.msg_len), e.len);
      end
    end
  endtask

  always @(negedge clk) mon_m();
  always @(negedge clk) mon_u();

  // Sink readiness: mode 0 always ready, mode 1 repeats 1,0,0,1.
  initial begin
    m_if.char_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1) begin
        m_if.char_ready = ((rdy_ph % 4) == 0) || ((rdy_ph % 4) == 3);
        rdy_ph++;
      end else begin
        m_if.char_ready = 1'b1;
        rdy_ph = 0;
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    m_if.start    = 1'b0;
    m_if.op       = '0;
    m_if.reg_dest = '0;
    m_if.valor    = '0;
    m_if.abort    = 1'b0;
    u_if.start    = 1'b0;
    u_if.op       = '0;
    u_if.reg_dest = '0;
    u_if.valor    = '0;
    u_if.abort    = 1'b0;
    u_if.char_ready = 1'b1;
    repeat (3) tick();
    check("rst_in_ready", m_if.in_ready, 1);
    check("rst_valid", m_if.char_valid, 0);
    check("rst_last", m_if.char_last, 0);
    check("rst_data", m_if.char_data, 0);
    check("rst_len", 32'(m_if.msg_len), 0);
    check("rst_u_in_ready", u_if.in_ready, 1);
    rst_n = 1'b1;
    tick();

    // ADD R1, +12 with exact first-character latency.
    drive_m(4'd1, 4'd1, 16'd12, 1'b1);
    check("t1_busy", m_if.in_ready, 0);
    repeat (16) tick();
    check("t1_not_yet", m_if.char_valid, 0);
    tick();
    check("t1_first_valid", m_if.char_valid, 1);
    check("t1_first_char", m_if.char_data, 8'h41);
    wait_m("t1_done");

    // SUBI R2, -13 under a stalling sink.
    rdy_mode = 1;
    drive_m(4'd4, 4'd2, 16'hFFF3, 1'b1);
    wait_m("t2_done");
    rdy_mode = 0;

    // Table of opcodes, register widths and value boundaries.
    for (int i = 0; i < 7; i++) begin
      drive_m(t_op[i], t_reg[i], t_val[i], 1'b1);
      wait_m("t3_done");
    end

    // Back-to-back requests: the second is taken as soon as in_ready returns.
    drive_m(4'd2, 4'd8, 16'd5, 1'b1);
    drive_m(4'd3, 4'd14, 16'hFC18, 1'b1);
    wait_m("t4_done");

    // Unsigned 8-bit instance: no sign character.
    drive_u(4'd2, 4'd5, 8'hFF);
    drive_u(4'd0, 4'd1, 8'h00);
    drive_u(4'd3, 4'd12, 8'd10);

    // Abort during conversion.
    drive_m(4'd1, 4'd3, 16'd55, 1'b0);
    repeat (5) tick();
    m_if.abort = 1'b1;
    tick();
    m_if.abort = 1'b0;
    check("t6_ready", m_if.in_ready, 1);
    quiet_window("t6_quiet", 30);

    // Abort on the same cycle as a character handshake.
    drive_m(4'd5, 4'd4, 16'd1234, 1'b1);
    repeat (17) tick();
    check("t7_first", m_if.char_valid, 1);
    repeat (3) tick();
    m_if.abort = 1'b1;
    tick();
    m_if.abort = 1'b0;
    check("t7_remaining", 32'(q_m.size()), 10);
    check("t7_valid", m_if.char_valid, 0);
    check("t7_ready", m_if.in_ready, 1);
    q_m.delete();
    quiet_window("t7_quiet", 20);

    // Start while busy is ignored.
    drive_m(4'd3, 4'd6, 16'd42, 1'b1);
    repeat (3) tick();
    m_if.op    = 4'd7;
    m_if.valor = 16'd999;
    m_if.start = 1'b1;
    repeat (3) tick();
    m_if.start = 1'b0;
    wait_m("t8_done");
    quiet_window("t8_quiet", 30);

    // Asynchronous reset mid-EMIT, then a fresh message.
    drive_m(4'd0, 4'd2, 16'd321, 1'b1);
    repeat (20) tick();
    check("t9_in_emit", m_if.char_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    check("t9_in_ready", m_if.in_ready, 1);
    check("t9_valid", m_if.char_valid, 0);
    check("t9_last", m_if.char_last, 0);
    check("t9_data", m_if.char_data, 0);
    check("t9_len", 32'(m_if.msg_len), 0);
    q_m.delete();
    #1 rst_n = 1'b1;
    tick();
    quiet_window("t9_quiet", 5);
    drive_m(4'd4, 4'd11, 16'hFF9C, 1'b1);
    wait_m("t9_done");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
